bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter SLAVE_LEN, default 2, width of the slave-select code; selects one of 2**SLAVE_LEN slaves.
REQ-002 Parameter TIMEOUT, default 255, maximum ACTIVE cycles before forced release (used only when ARB_TIMEOUT_EN is defined).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m1_request, m2_request  input  1 each  bus request from master 1 and master 2; a master holds it high until its transfer is done.
REQ-006 m1_slave_select, m2_slave_select  input  1 each  serial slave code from each master, MSB first.
REQ-007 m1_trans_done, m2_trans_done  input  1 each  end-of-transfer pulse from each master.
REQ-008 m1_grant, m2_grant  output  1 each  bus grant to each master; the two grants are never high together.
REQ-009 master_sel  output  1  datapath mux control: 0 = master 1, 1 = master 2; holds its last value when idle.
REQ-010 slave_en  output  2**SLAVE_LEN  one-hot enable of the addressed slave; all zero outside ACTIVE.
REQ-011 arbiter_busy  output  1  high in every state except IDLE.
REQ-012 bus_busy  output  1  high only in ACTIVE.
REQ-013 timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-014 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.
REQ-015 States: IDLE, SSEL, ACTIVE, RELEASE; the state register and a last_served flag are the only control state.
REQ-016 IDLE: on any request high at edge N, the block SHALL enter SSEL and assert the winner's grant, visible after edge N.
REQ-017 Arbitration is round-robin: with a single requester, that master wins; with both requesting, the master not equal to last_served wins.
REQ-018 On each grant, last_served SHALL be updated to the winner, and master_sel SHALL be set to the winner.
REQ-019 SSEL: the winner's slave_select line SHALL be sampled for exactly SLAVE_LEN consecutive cycles, MSB first, beginning on the first edge after grant rises; after the last sample the block SHALL enter ACTIVE.
REQ-020 ACTIVE: slave_en SHALL be the one-hot decode of the received code and bus_busy = 1; the grant stays high.
REQ-021 The granted master's trans_done in ACTIVE SHALL move the block to RELEASE.
REQ-022 A trans_done from the non-granted master SHALL be ignored in every state.
REQ-023 A granted master's request going low in SSEL or ACTIVE SHALL move the block to RELEASE (abandon); the partial code is discarded.
REQ-024 trans_done arriving together with the request falling SHALL produce a single RELEASE.
REQ-025 RELEASE lasts exactly one cycle with all grants = 0, slave_en = 0, bus_busy = 0 and arbiter_busy = 1; the next state is IDLE unconditionally.
REQ-026 A request held through RELEASE SHALL be arbitrated in the following IDLE cycle; the minimum gap between two grants is 2 cycles.
REQ-027 Request inputs SHALL be ignored outside IDLE, except for the granted master's request per REQ-023.

Reset
REQ-028 When reset is high, the block SHALL immediately force: state = IDLE; last_served = master 2 (so master 1 wins the first tie); master_sel = 0; grants = 0; slave_en = 0; arbiter_busy = 0; bus_busy = 0; timeout = 0; the shift register and timeout counter cleared.
REQ-029 Reset asserted mid-SSEL or mid-ACTIVE SHALL drop the grant and slave_en asynchronously, with no RELEASE cycle.

Configuration
REQ-030 Macro ARB_TIMEOUT_EN, when defined, SHALL enable a counter that clears on ACTIVE entry and increments each ACTIVE cycle.
REQ-031 With ARB_TIMEOUT_EN defined: when the counter reaches TIMEOUT with no trans_done, the block SHALL enter RELEASE and pulse timeout for that RELEASE cycle; trans_done on the same edge takes precedence and timeout stays 0.
REQ-032 Without ARB_TIMEOUT_EN: no counter is synthesized, the timeout port remains present and is tied to 0, and ACTIVE lasts indefinitely.

Verification
REQ-033 m1_request rises at cycle 0, serial bits 1,0 -> m1_grant=1 at cycle 1, bus_busy=1 at cycle 3, slave_en=4'b0100; m1_trans_done at cycle 6 -> RELEASE at 7, IDLE at 8.
REQ-034 Both requests high from reset and held -> grants alternate m1, m2, m1 in turn, with master_sel following the granted master.
REQ-035 m2 granted, m2_request dropped after 1 SSEL cycle -> RELEASE with slave_en never nonzero and timeout=0.
REQ-036 m1 in ACTIVE, m2_trans_done pulsed -> no state change; reset pulsed in ACTIVE -> all outputs 0 immediately.
REQ-037 With ARB_TIMEOUT_EN and TIMEOUT=4, no trans_done -> RELEASE after 4 ACTIVE cycles with timeout=1 for one cycle; without the macro -> still ACTIVE after 1000 cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with serial slave select and registered outputs.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT cycles in ACTIVE.
module bus_arbiter #(
    parameter int SLAVE_LEN = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m1_request,
    input  logic                      m2_request,
    input  logic                      m1_slave_select,
    input  logic                      m2_slave_select,
    input  logic                      m1_trans_done,
    input  logic                      m2_trans_done,
    output logic                      m1_grant,
    output logic                      m2_grant,
    output logic                      master_sel,
    output logic [2**SLAVE_LEN-1:0]   slave_en,
    output logic                      arbiter_busy,
    output logic                      bus_busy,
    output logic                      timeout
);

    localparam int N  = 2**SLAVE_LEN;
    localparam int BW = (SLAVE_LEN > 1) ? $clog2(SLAVE_LEN) : 1;

    typedef enum logic [1:0] {IDLE, SSEL, ACTIVE, RELEASE} state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic                 sel_d;
    logic [SLAVE_LEN-1:0] shift_q, shift_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [N-1:0]         slave_en_d;
    logic                 timeout_d;
    logic                 win;
    logic                 own_req, own_bit, own_done;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // master_sel always names the current owner while granted
    assign own_req  = master_sel ? m2_request      : m1_request;
    assign own_bit  = master_sel ? m2_slave_select : m1_slave_select;
    assign own_done = master_sel ? m2_trans_done   : m1_trans_done;
    assign win      = (m1_request && m2_request) ? ~last_q : m2_request;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        sel_d      = master_sel;
        shift_d    = shift_q;
        bcnt_d     = bcnt_q;
        slave_en_d = '0;
        timeout_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (m1_request || m2_request) begin
                    state_d = SSEL;
                    last_d  = win;
                    sel_d   = win;
                    shift_d = '0;
                    bcnt_d  = '0;
                end
            end
            SSEL: begin
                if (!own_req) begin
                    state_d = RELEASE;
                end else begin
                    shift_d = SLAVE_LEN'({shift_q, own_bit});
                    bcnt_d  = bcnt_q + BW'(1);
                    if (bcnt_q == BW'(SLAVE_LEN - 1)) begin
                        state_d    = ACTIVE;
                        slave_en_d = {{(N-1){1'b0}}, 1'b1} << shift_d;
`ifdef ARB_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end
                end
            end
            ACTIVE: begin
                if (own_done || !own_req) begin
                    state_d = RELEASE;
                end else begin
                    slave_en_d = slave_en;
`ifdef ARB_TIMEOUT_EN
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d    = RELEASE;
                        slave_en_d = '0;
                        timeout_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
`endif
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            master_sel   <= 1'b0;
            shift_q      <= '0;
            bcnt_q       <= '0;
            m1_grant     <= 1'b0;
            m2_grant     <= 1'b0;
            slave_en     <= '0;
            arbiter_busy <= 1'b0;
            bus_busy     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            master_sel   <= sel_d;
            shift_q      <= shift_d;
            bcnt_q       <= bcnt_d;
            m1_grant     <= (state_d == SSEL || state_d == ACTIVE) && !sel_d;
            m2_grant     <= (state_d == SSEL || state_d == ACTIVE) && sel_d;
            slave_en     <= slave_en_d;
            arbiter_busy <= (state_d != IDLE);
            bus_busy     <= (state_d == ACTIVE);
            timeout      <= timeout_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

endmodule
